// File: rtl/prog_lut_eval.sv
// Programmable multi-channel LUT evaluator: N_CH truth tables share one input vector,
// behind a two-stage valid/ready pipeline with a configuration port that only writes when idle.
module prog_lut_eval #(
    parameter int unsigned N_IN = 3,
    parameter int unsigned N_CH = 2,
    parameter logic [(2**N_IN)-1:0] RST_TABLE = '0
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       cfg_valid,
    output logic                                       cfg_ready,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
    input  logic [(2**N_IN)-1:0]                       cfg_table,
    input  logic                                       cfg_inv,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [N_IN-1:0]                            in_x,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [N_CH-1:0]                            out_y,
    output logic                                       cfg_err,
    output logic [15:0]                                out_cnt
);

    localparam int unsigned TW = 2**N_IN;
    localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [TW-1:0]   tbl [N_CH];
    logic [N_CH-1:0] inv;

    logic            s1_valid;
    logic [N_IN-1:0] s1_x;

    logic            s2_free;
    logic            s1_adv;
    logic            out_fire;
    logic            cfg_fire;
    logic            in_fire;
    logic            ch_ok;
    logic [N_CH-1:0] lookup;

    // Handshake decode; configuration only while both stages are empty and wins over input.
    always_comb begin
        s2_free   = !out_valid || out_ready;
        s1_adv    = s1_valid && s2_free;
        out_fire  = out_valid && out_ready;
        cfg_ready = rst_n && !s1_valid && !out_valid;
        cfg_fire  = cfg_valid && cfg_ready;
        in_ready  = rst_n && (!s1_valid || s1_adv) && !cfg_fire;
        in_fire   = in_valid && in_ready;
        ch_ok     = 32'(cfg_ch) < N_CH;
    end

    // Table lookup of the S1 vector, applied at the S1->S2 edge.
    always_comb begin
        lookup = '0;
        for (int c = 0; c < N_CH; c++) begin
            lookup[c] = tbl[c][s1_x] ^ inv[c];
        end
    end

    // Pipeline stages and transfer counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_cnt   <= '0;
        end else begin
            if (s1_adv) begin
                out_y     <= lookup;
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end

            if (in_fire) begin
                s1_x     <= in_x;
                s1_valid <= 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end

            if (out_fire) begin
                out_cnt <= out_cnt + 16'd1;
            end
        end
    end

    // Channel tables and the sticky out-of-range write flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                tbl[c] <= RST_TABLE;
            end
            inv     <= '0;
            cfg_err <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (cfg_fire && ch_ok && (cfg_ch == CW'(c))) begin
                    tbl[c] <= cfg_table;
                    inv[c] <= cfg_inv;
                end
            end
            if (cfg_fire && !ch_ok) begin
                cfg_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_lut_eval.sv
// Bench for prog_lut_eval: directed scenarios plus randomized traffic against a
// truth-table / FIFO reference model; a second instance with N_CH=3 covers out-of-range writes.
module tb_prog_lut_eval;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: N_IN=3, N_CH=2, all-zero reset table
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [0:0]  cfg_ch = '0;
    logic [7:0]  cfg_table = '0;
    logic        cfg_inv = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_x = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_y;
    logic        cfg_err;
    logic [15:0] out_cnt;

    // Second instance: N_CH=3 so an index of 3 is expressible, reset table 8'h3C
    logic        rst_n_b = 1'b0;
    logic        cfg_valid_b = 1'b0;
    logic        cfg_ready_b;
    logic [1:0]  cfg_ch_b = '0;
    logic [7:0]  cfg_table_b = '0;
    logic        cfg_inv_b = 1'b0;
    logic        in_valid_b = 1'b0;
    logic        in_ready_b;
    logic [2:0]  in_x_b = '0;
    logic        out_valid_b;
    logic        out_ready_b = 1'b1;
    logic [2:0]  out_y_b;
    logic        cfg_err_b;
    logic [15:0] out_cnt_b;

    prog_lut_eval #(.N_IN(3), .N_CH(2), .RST_TABLE(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_table(cfg_table), .cfg_inv(cfg_inv),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .cfg_err(cfg_err), .out_cnt(out_cnt)
    );

    prog_lut_eval #(.N_IN(3), .N_CH(3), .RST_TABLE(8'h3C)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
        .cfg_ch(cfg_ch_b), .cfg_table(cfg_table_b), .cfg_inv(cfg_inv_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_x(in_x_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_y(out_y_b),
        .cfg_err(cfg_err_b), .out_cnt(out_cnt_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: truth tables, inversion bits, FIFO of expected results
    logic [7:0]  mtbl [2];
    logic [1:0]  minv;
    logic [1:0]  exp_q [$];
    logic [1:0]  obs_log [$];
    logic [15:0] mcnt;
    logic        merr;
    logic        last_in_f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_y(input logic [2:0] x);
        logic [1:0] y;
        for (int c = 0; c < 2; c++) begin
            y[c] = (((mtbl[c] >> x) & 8'd1) != 8'd0) ^ minv[c];
        end
        return y;
    endfunction

    // One clock of the main instance: called just after a negedge with inputs already driven.
    task automatic cycle();
        logic exp_cr;
        logic exp_ir;
        logic cfg_f;
        logic in_f;
        logic out_f;
        logic [1:0] push_v;
        #1;
        if (!rst_n) begin
            chk("in_ready_in_reset", 32'(in_ready), 0);
            chk("cfg_ready_in_reset", 32'(cfg_ready), 0);
            @(posedge clk);
            exp_q.delete();
            mcnt = '0;
            merr = 1'b0;
            mtbl[0] = 8'h00;
            mtbl[1] = 8'h00;
            minv = '0;
            last_in_f = 1'b0;
            @(negedge clk);
            return;
        end
        exp_cr = (exp_q.size() == 0);
        cfg_f  = cfg_valid && exp_cr;
        exp_ir = !((exp_q.size() == 2) && !out_ready) && !cfg_f;
        chk("cfg_ready", 32'(cfg_ready), 32'(exp_cr));
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("out_cnt", 32'(out_cnt), 32'(mcnt));
        chk("cfg_err", 32'(cfg_err), 32'(merr));
        out_f = 1'b0;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 0);
            end else begin
                chk("out_y", 32'(out_y), 32'(exp_q[0]));
                out_f = out_ready;
            end
        end
        in_f   = in_valid && exp_ir;
        push_v = model_y(in_x);
        @(posedge clk);
        if (out_f) begin
            void'(exp_q.pop_front());
            obs_log.push_back(out_y);
            mcnt = mcnt + 16'd1;
        end
        if (cfg_f) begin
            mtbl[cfg_ch] = cfg_table;
            minv[cfg_ch] = cfg_inv;
        end
        if (in_f) exp_q.push_back(push_v);
        last_in_f = in_f;
        @(negedge clk);
    endtask

    logic [1:0] seq035 [8];
    int sent;

    initial begin
        seq035 = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
        @(negedge clk);
        cycle();
        cycle();
        rst_n   = 1'b1;
        rst_n_b = 1'b1;

        // Single evaluation after reset: latency and all-zero reset table
        in_valid = 1'b1;
        in_x = 3'd5;
        cycle();
        in_valid = 1'b0;
        #1 chk("lat_stage1_only", 32'(out_valid), 0);
        cycle();
        #1 chk("lat_out_valid", 32'(out_valid), 1);
        chk("lat_out_y", 32'(out_y), 0);
        cycle();
        #1 chk("cnt_after_first", 32'(out_cnt), 1);

        // Program both channels with 8'h96, channel 1 inverted, then stream 0..7
        cfg_valid = 1'b1;
        cfg_ch = 1'b0;
        cfg_table = 8'h96;
        cfg_inv = 1'b0;
        cycle();
        cfg_ch = 1'b1;
        cfg_inv = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        obs_log.delete();
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8);
            in_x = 3'(i);
            cycle();
        end
        in_valid = 1'b0;
        #1 chk("stream_cnt", 32'(out_cnt), 9);
        chk("stream_len", 32'(obs_log.size()), 8);
        for (int i = 0; i < 8 && i < obs_log.size(); i++) begin
            chk($sformatf("stream_y%0d", i), 32'(obs_log[i]), 32'(seq035[i]));
        end

        // Four inputs with a three-cycle output stall in the middle
        sent = 0;
        obs_log.delete();
        for (int i = 0; i < 20; i++) begin
            in_valid = (sent < 4);
            in_x = 3'($urandom);
            out_ready = !(i >= 2 && i <= 4);
            cycle();
            if (last_in_f) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 chk("stall_len", 32'(obs_log.size()), 4);
        chk("stall_cnt", 32'(out_cnt), 13);

        // Simultaneous config and input on an empty pipeline: config wins, input uses new table
        cfg_valid = 1'b1;
        cfg_ch = 1'b0;
        cfg_table = 8'hFF;
        cfg_inv = 1'b0;
        in_valid = 1'b1;
        in_x = 3'd3;
        cycle();
        cfg_valid = 1'b0;
        obs_log.delete();
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        #1 chk("cfg_win_len", 32'(obs_log.size()), 1);
        if (obs_log.size() > 0) chk("cfg_win_y", 32'(obs_log[0]), 32'(2'b11));

        // Reset pulse mid-stream discards in-flight data and restores reset tables
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_x = 3'($urandom);
            cycle();
        end
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1 chk("post_rst_out_valid", 32'(out_valid), 0);
        chk("post_rst_out_cnt", 32'(out_cnt), 0);
        chk("post_rst_cfg_err", 32'(cfg_err), 0);
        chk("post_rst_cfg_ready", 32'(cfg_ready), 1);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_x = 3'd7;
        cycle();
        in_valid = 1'b0;
        cycle();
        #1 chk("post_rst_table_y", 32'(out_y), 0);
        chk("post_rst_table_valid", 32'(out_valid), 1);
        cycle();

        // Randomized traffic with occasional reconfiguration
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_x      = 3'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            cfg_valid = ($urandom_range(0, 15) == 0);
            cfg_ch    = 1'($urandom);
            cfg_table = 8'($urandom);
            cfg_inv   = 1'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        cfg_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
        chk("drain_empty", 32'(exp_q.size()), 0);
        #1 chk("final_cnt", 32'(out_cnt), 32'(mcnt));

        // Out-of-range channel write on the three-channel instance
        cfg_valid_b = 1'b1;
        cfg_ch_b = 2'd3;
        cfg_table_b = 8'h00;
        cfg_inv_b = 1'b1;
        cycle();
        cfg_valid_b = 1'b0;
        #1 chk("b_cfg_err_set", 32'(cfg_err_b), 1);
        in_valid_b = 1'b1;
        in_x_b = 3'd2;
        cycle();
        in_valid_b = 1'b0;
        cycle();
        #1 chk("b_tables_unchanged", 32'(out_y_b), 32'(3'b111));
        cycle();
        cfg_valid_b = 1'b1;
        cfg_ch_b = 2'd2;
        cycle();
        cfg_valid_b = 1'b0;
        #1 chk("b_cfg_err_sticky", 32'(cfg_err_b), 1);
        in_valid_b = 1'b1;
        in_x_b = 3'd0;
        cycle();
        in_valid_b = 1'b0;
        cycle();
        #1 chk("b_ch2_written", 32'(out_y_b), 32'(3'b100));
        cycle();
        #1 chk("b_out_cnt", 32'(out_cnt_b), 2);
        rst_n_b = 1'b0;
        cycle();
        rst_n_b = 1'b1;
        #1 chk("b_rst_cfg_err", 32'(cfg_err_b), 0);
        chk("b_rst_out_cnt", 32'(out_cnt_b), 0);
        in_valid_b = 1'b1;
        in_x_b = 3'd0;
        cycle();
        in_valid_b = 1'b0;
        cycle();
        #1 chk("b_rst_tables", 32'(out_y_b), 32'(3'b000));
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
